// File: rtl/ext_code_pkg.sv
// ext_code_pkg: shared types and helpers for the external code sequencer.
package ext_code_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Index width that never collapses to zero bits for tiny depths.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ext_code_trig_sync.sv
// ext_code_trig_sync: trigger conditioning and edge detection.
// With EXT_CODE_TRIG_SYNC_EN defined the trigger passes through a 2-flop
// synchronizer; otherwise it is taken as already synchronous to clk.
module ext_code_trig_sync (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic rise,
  output logic fall
);

  logic trg_s;
  logic prev;
  logic armed;

`ifdef EXT_CODE_TRIG_SYNC_EN
  logic trig_p0;
  logic trig_p1;

  // Synchronizer stages p0/p1; left unreset so a trigger held through reset still reads high.
  always_ff @(posedge clk) begin
    trig_p0 <= trig;
    trig_p1 <= trig_p0;
  end

  assign trg_s = trig_p1;
`else
  assign trg_s = trig;
`endif

  // Edge history plus arm flag: after reset a low level must be seen before a rise counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      prev <= trg_s;
      if (!trg_s) armed <= 1'b1;
    end
  end

  assign rise = trg_s & ~prev & armed;
  assign fall = ~trg_s & prev;

endmodule

// File: rtl/ext_code_seq.sv
// ext_code_seq: external code sequencer. Host loads DEPTH code words and a
// start index; each trigger pulse drives the indexed code, then steps the
// index up or down with optional wrap. Optional macro: EXT_CODE_TRIG_SYNC_EN
// (adds a 2-flop trigger synchronizer, +2 cycles trigger latency).
module ext_code_seq
  import ext_code_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int IDX_W = clog2_min1(DEPTH)
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iSET_CODE_FLAG,
  input  logic [WIDTH-1:0] iSET_CODE,
  input  logic             iSET_INDEX_FLAG,
  input  logic [IDX_W-1:0] iSET_INDEX,
  input  logic             iDir,
  input  logic             iWrap,
  input  logic             iTrigger,
  output logic [WIDTH-1:0] oCode,
  output logic [IDX_W-1:0] oIndex,
  output logic             oActive,
  output logic             oDone
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  logic [WIDTH-1:0] storage [DEPTH];
  logic             rise;
  logic             fall;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_step;
  logic [IDX_W-1:0] idx_set;
  logic             done_step;
  logic [WIDTH-1:0] code;
  logic             active;
  logic             done;

  ext_code_trig_sync u_trig (
    .clk  (iClk),
    .rst  (iRst),
    .trig (iTrigger),
    .rise (rise),
    .fall (fall)
  );

  // Out-of-range set values clamp to the last entry; a full power-of-two range needs no clamp.
  generate
    if (DEPTH == (1 << IDX_W)) begin : g_noclamp
      assign idx_set = iSET_INDEX;
    end else begin : g_clamp
      assign idx_set = (iSET_INDEX > LAST) ? LAST : iSET_INDEX;
    end
  endgenerate

  // Host write into code storage at the index held before any same-cycle update.
  always_ff @(posedge iClk) begin
    if (iSET_CODE_FLAG) storage[idx] <= iSET_CODE;
  end

  // Next index for a step, and whether the step runs off an unwrapped end.
  always_comb begin
    idx_step  = idx;
    done_step = 1'b0;
    if (dir_e'(iDir) == DIR_UP) begin
      if (idx != LAST)  idx_step = idx + 1'b1;
      else if (iWrap)   idx_step = '0;
      else              done_step = 1'b1;
    end else begin
      if (idx != '0)    idx_step = idx - 1'b1;
      else if (iWrap)   idx_step = LAST;
      else              done_step = 1'b1;
    end
  end

  // Output register and index state; a host set-index overrides a same-cycle step.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      idx    <= '0;
      code   <= '0;
      active <= 1'b0;
      done   <= 1'b0;
    end else begin
      if (rise && !done) begin
        active <= 1'b1;
        code   <= storage[idx];
      end else if (fall && active) begin
        active <= 1'b0;
        code   <= '0;
        idx    <= idx_step;
        if (done_step) done <= 1'b1;
      end
      if (iSET_INDEX_FLAG) begin
        idx  <= idx_set;
        done <= 1'b0;
      end
    end
  end

  assign oCode   = code;
  assign oIndex  = idx;
  assign oActive = active;
  assign oDone   = done;

endmodule
